// File: rtl/hazard_pkg.sv
// Shared types and constants for the Otter pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Pipeline register controls, MSB first in port order.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctl_t;

  localparam hz_ctl_t CTL_NONE   = 7'b0000_000;
  localparam hz_ctl_t CTL_RESET  = 7'b0000_111;
  localparam hz_ctl_t CTL_FREEZE = 7'b1111_001;
  localparam hz_ctl_t CTL_BRANCH = 7'b0000_110;
  localparam hz_ctl_t CTL_BUBBLE = 7'b1100_010;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding select for one E-stage ALU operand; M result wins over W result.
module hazard_fwd_unit (
  input  logic [4:0] rs_E,
  input  logic [4:0] rd_M,
  input  logic       regWrite_M,
  input  logic [4:0] rd_W,
  input  logic       regWrite_W,
  output logic [1:0] fwd_sel
);
  import hazard_pkg::*;

  always_comb begin
    fwd_sel = FWD_RF;
    if (regWrite_M && (rd_M != REG_ZERO) && (rd_M == rs_E))
      fwd_sel = FWD_MEM;
    else if (regWrite_W && (rd_W != REG_ZERO) && (rd_W == rs_E))
      fwd_sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage Otter pipeline: stalls, flushes, forwarding,
// memory-wait freeze with timeout halt, and stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             rs1_used_D,
  input  logic             rs2_used_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             memRead_E,
  input  logic             pcSrc_E,
  input  logic [4:0]       rd_M,
  input  logic             regWrite_M,
  input  logic             dmem_req_M,
  input  logic             dmem_ready,
  input  logic [4:0]       rd_W,
  input  logic             regWrite_W,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       fwdA_E,
  output logic [1:0]       fwdB_E,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import hazard_pkg::*;

  localparam int              WC_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  hz_state_t       state, state_nxt;
  logic [WC_W-1:0] wait_cnt;
  hz_ctl_t         ctl;
  logic            br_evt;
  logic            mem_miss;
  logic            load_use;
  logic            frozen;
  logic [1:0]      fwd_a, fwd_b;

  assign mem_miss = dmem_req_M & ~dmem_ready;
  assign load_use = memRead_E & (rd_E != REG_ZERO) &
                    ((rs1_used_D & (rd_E == rs1_D)) | (rs2_used_D & (rd_E == rs2_D)));

  // Once waiting, only dmem_ready matters: the access in M is already committed.
  assign frozen = (state == HALT) ||
                  ((state == MEM_WAIT) && !dmem_ready) ||
                  ((state == RUN) && mem_miss);

  always_ff @(negedge CLK) begin
    if (!RST_N) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_miss) state_nxt = MEM_WAIT;
      MEM_WAIT: begin
        if (dmem_ready)             state_nxt = RUN;
        else if (wait_cnt == WC_LAST) state_nxt = HALT;
      end
      HALT:     state_nxt = HALT;
      default:  state_nxt = RUN;
    endcase
  end

  always_comb begin
    ctl    = CTL_NONE;
    br_evt = 1'b0;
    if (!RST_N)          ctl = CTL_RESET;
    else if (frozen)     ctl = CTL_FREEZE;
    else if (pcSrc_E) begin
      ctl    = CTL_BRANCH;
      br_evt = 1'b1;
    end
    else if (load_use)   ctl = CTL_BUBBLE;
  end

  assign {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W} = ctl;

  always_ff @(negedge CLK) begin
    if (!RST_N) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (state == RUN && state_nxt == MEM_WAIT)
        wait_cnt <= WC_W'(1);
      else if (state == MEM_WAIT && state_nxt == MEM_WAIT)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == MEM_WAIT && state_nxt == HALT)
        err_timeout <= 1'b1;
      if (ctl.stall_f) stall_cnt <= stall_cnt + 1'b1;
      if (br_evt)      flush_cnt <= flush_cnt + 1'b1;
    end
  end

  hazard_fwd_unit u_fwd_a (
    .rs_E       (rs1_E),
    .rd_M       (rd_M),
    .regWrite_M (regWrite_M),
    .rd_W       (rd_W),
    .regWrite_W (regWrite_W),
    .fwd_sel    (fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .rs_E       (rs2_E),
    .rd_M       (rd_M),
    .regWrite_M (regWrite_M),
    .rd_W       (rd_W),
    .regWrite_W (regWrite_W),
    .fwd_sel    (fwd_b)
  );

  assign fwdA_E = RST_N ? fwd_a : FWD_RF;
  assign fwdB_E = RST_N ? fwd_b : FWD_RF;

endmodule
